// File: rtl/riscv_hazard_pkg.sv
// rtl/riscv_hazard_pkg.sv - opcode constants and source-operand decode for the hazard unit
package riscv_hazard_pkg;

  localparam logic [6:0] OP_R      = 7'd51;
  localparam logic [6:0] OP_I      = 7'd19;
  localparam logic [6:0] OP_LOAD   = 7'd3;
  localparam logic [6:0] OP_STORE  = 7'd35;
  localparam logic [6:0] OP_BRANCH = 7'd99;
  localparam logic [6:0] OP_JALR   = 7'd103;

  function automatic logic uses_rs1(input logic [6:0] opcode);
    return opcode inside {OP_R, OP_I, OP_LOAD, OP_STORE, OP_BRANCH, OP_JALR};
  endfunction

  function automatic logic uses_rs2(input logic [6:0] opcode);
    return opcode inside {OP_R, OP_STORE, OP_BRANCH};
  endfunction

endpackage

// File: rtl/load_scoreboard.sv
// rtl/load_scoreboard.sv - per-register countdown of cycles until load data is forwardable
module load_scoreboard
  import riscv_hazard_pkg::*;
#(
  parameter int NREGS    = 32,
  parameter int CNT_W    = 3,
  parameter int LOAD_LAT = 1,
  localparam int AW      = $clog2(NREGS)
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        capture,
  input  logic [AW-1:0]               capture_rd,
  input  logic                        advance,
  output logic [NREGS-1:0][CNT_W-1:0] cnt,
  output logic                        busy
);

  logic [NREGS-1:0][CNT_W-1:0] cnt_q, cnt_d;

  // A fresh load restarts its register's countdown even if one is already running.
  always_comb begin
    cnt_d = cnt_q;
    for (int r = 1; r < NREGS; r++) begin
      if (advance) begin
        if (capture && capture_rd == AW'(r)) begin
          cnt_d[r] = CNT_W'(LOAD_LAT);
        end else if (cnt_q[r] != '0) begin
          cnt_d[r] = cnt_q[r] - CNT_W'(1);
        end
      end
    end
    cnt_d[0] = '0;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt  = cnt_q;
  assign busy = |cnt_q;

endmodule

// File: rtl/hazard_scoreboard_unit.sv
// rtl/hazard_scoreboard_unit.sv - ID-stage hazard detection with load scoreboard and stall counter
module hazard_scoreboard_unit
  import riscv_hazard_pkg::*;
#(
  parameter int NREGS    = 32,
  parameter int REG_AW   = 5,
  parameter int LOAD_LAT = 1,
  parameter int BR_IN_ID = 1,
  parameter int CNT_W    = 3,
  parameter int PERF_W   = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [31:0]       id_instr,
  input  logic              id_valid,
  input  logic              ex_mem_read,
  input  logic              ex_reg_write,
  input  logic [REG_AW-1:0] ex_rd,
  input  logic              mem_wait,
  input  logic              flush,
  output logic              pc_write,
  output logic              if_id_write,
  output logic              id_ex_bubble,
  output logic              hazard_busy,
  output logic [PERF_W-1:0] stall_cnt
);

  logic [6:0]                  opcode;
  logic [1:0][REG_AW-1:0]      src;
  logic [1:0]                  used;
  logic                        ex_load, ex_alu, br_id, hazard, stall_inc;
  logic [NREGS-1:0][CNT_W-1:0] cnt;
  logic [PERF_W-1:0]           stall_cnt_q, stall_cnt_d;
  logic                        unused_instr_bits;

  assign opcode            = id_instr[6:0];
  assign src               = {id_instr[20 +: REG_AW], id_instr[15 +: REG_AW]};
  assign used              = {uses_rs2(opcode) && src[1] != '0, uses_rs1(opcode) && src[0] != '0};
  assign ex_load           = ex_mem_read && ex_reg_write && ex_rd != '0;
  assign ex_alu            = ex_reg_write && !ex_mem_read && ex_rd != '0;
  assign br_id             = (BR_IN_ID != 0) && (opcode == OP_BRANCH);
  assign unused_instr_bits = ^{id_instr[31:25], id_instr[14:7]};

  load_scoreboard #(
    .NREGS   (NREGS),
    .CNT_W   (CNT_W),
    .LOAD_LAT(LOAD_LAT)
  ) u_sb (
    .clk       (clk),
    .reset     (reset),
    .capture   (!mem_wait && ex_load),
    .capture_rd(ex_rd),
    .advance   (!mem_wait),
    .cnt       (cnt),
    .busy      (hazard_busy)
  );

  // A branch compared in ID needs the data one cycle earlier than an EX consumer.
  always_comb begin
    hazard = 1'b0;
    for (int i = 0; i < 2; i++) begin
      if (used[i]) begin
        if (ex_load && ex_rd == src[i]) hazard = 1'b1;
        if (br_id ? (cnt[src[i]] != '0) : (cnt[src[i]] > CNT_W'(1))) hazard = 1'b1;
        if (br_id && ex_alu && ex_rd == src[i]) hazard = 1'b1;
      end
    end
  end

  always_comb begin
    pc_write     = 1'b1;
    if_id_write  = 1'b1;
    id_ex_bubble = 1'b0;
    if (reset) begin
      pc_write     = 1'b0;
      if_id_write  = 1'b0;
      id_ex_bubble = 1'b1;
    end else if (mem_wait) begin
      pc_write    = 1'b0;
      if_id_write = 1'b0;
    end else if (flush) begin
      id_ex_bubble = 1'b1;
    end else if (hazard && id_valid) begin
      pc_write     = 1'b0;
      if_id_write  = 1'b0;
      id_ex_bubble = 1'b1;
    end
  end

  assign stall_inc   = !mem_wait && !flush && hazard && id_valid;
  assign stall_cnt_d = (stall_inc && stall_cnt_q != '1) ? stall_cnt_q + PERF_W'(1) : stall_cnt_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      stall_cnt_q <= '0;
    end else begin
      stall_cnt_q <= stall_cnt_d;
    end
  end

  assign stall_cnt = stall_cnt_q;

endmodule

// File: tb/tb_hazard_scoreboard_unit.sv
// tb/tb_hazard_scoreboard_unit.sv - directed and randomized checks of four hazard unit configurations
module tb_hazard_scoreboard_unit;

  localparam int ND = 4;
  localparam logic [15:0] LLS = {4'd2, 4'd2, 4'd3, 4'd1};
  localparam logic [3:0]  BRS = 4'b0111;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [31:0] id_instr = '0;
  logic        id_valid = 1'b0, ex_mem_read = 1'b0, ex_reg_write = 1'b0;
  logic        mem_wait = 1'b0, flush = 1'b0;
  logic [4:0]  ex_rd = '0;
  logic [ND-1:0] pcw, ifw, bub, busy;
  logic [31:0] sc [ND];

  always #5 clk = ~clk;

  for (genvar g = 0; g < ND; g++) begin : g_dut
    localparam int PW = (g == 3) ? 4 : 32;
    logic [PW-1:0] sc_w;
    hazard_scoreboard_unit #(
      .NREGS(32), .REG_AW(5), .LOAD_LAT(int'(LLS[g*4 +: 4])), .BR_IN_ID(int'(BRS[g])),
      .CNT_W(3), .PERF_W(PW)
    ) u_dut (
      .clk(clk), .reset(reset), .id_instr(id_instr), .id_valid(id_valid),
      .ex_mem_read(ex_mem_read), .ex_reg_write(ex_reg_write), .ex_rd(ex_rd),
      .mem_wait(mem_wait), .flush(flush), .pc_write(pcw[g]), .if_id_write(ifw[g]),
      .id_ex_bubble(bub[g]), .hazard_busy(busy[g]), .stall_cnt(sc_w)
    );
    assign sc[g] = 32'(sc_w);
  end

  int          ll [ND] = '{1, 3, 2, 2};
  int          br [ND] = '{1, 1, 1, 0};
  longint      scmax [ND] = '{64'hFFFF_FFFF, 64'hFFFF_FFFF, 64'hFFFF_FFFF, 64'd15};
  int unsigned ready [ND][32];
  int unsigned tick;
  longint      exp_sc [ND];
  bit          hz [ND];
  logic [ND-1:0] last_pcw, last_bub;
  int          checks = 0;
  int          failures = 0;

  function automatic logic [31:0] mk(input logic [6:0] op, input logic [4:0] rd,
                                     input logic [4:0] rs1, input logic [4:0] rs2);
    return {7'd0, rs2, rs1, 3'd0, rd, op};
  endfunction

  // Ready times are absolute: a register is forwardable once tick reaches ready[d][r].
  function automatic bit model_hazard(input int d);
    logic [6:0] op;
    logic [4:0] s [2];
    bit u [2];
    bit bid, h;
    int unsigned rem;
    op = id_instr[6:0];
    s[0] = id_instr[19:15];
    s[1] = id_instr[24:20];
    u[0] = (op inside {7'd51, 7'd19, 7'd3, 7'd35, 7'd99, 7'd103}) && s[0] != 0;
    u[1] = (op inside {7'd51, 7'd35, 7'd99}) && s[1] != 0;
    bid = (br[d] != 0) && op == 7'd99;
    h = 0;
    for (int i = 0; i < 2; i++) begin
      if (u[i]) begin
        rem = (ready[d][s[i]] > tick) ? ready[d][s[i]] - tick : 0;
        if (ex_mem_read && ex_reg_write && ex_rd == s[i]) h = 1;
        if (bid ? (rem >= 1) : (rem > 1)) h = 1;
        if (bid && ex_reg_write && !ex_mem_read && ex_rd == s[i]) h = 1;
      end
    end
    return h;
  endfunction

  task automatic check(input string tag, input int d, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s dut%0d observed=%0h expected=%0h", tag, d, obs, exp);
    end
  endtask

  task automatic check_outputs();
    logic [2:0] e;
    bit b;
    for (int d = 0; d < ND; d++) begin
      hz[d] = model_hazard(d);
      if (reset)                     e = 3'b001;
      else if (mem_wait)             e = 3'b000;
      else if (flush)                e = 3'b111;
      else if (hz[d] && id_valid)    e = 3'b001;
      else                           e = 3'b110;
      b = 0;
      for (int r = 1; r < 32; r++) if (ready[d][r] > tick) b = 1;
      check("pc_write", d, 32'(pcw[d]), 32'(e[2]));
      check("if_id_write", d, 32'(ifw[d]), 32'(e[1]));
      check("id_ex_bubble", d, 32'(bub[d]), 32'(e[0]));
      check("hazard_busy", d, 32'(busy[d]), 32'(b));
      check("stall_cnt", d, sc[d], 32'(exp_sc[d]));
    end
  endtask

  task automatic cycle();
    #1;
    check_outputs();
    last_pcw = pcw;
    last_bub = bub;
    @(posedge clk);
    if (!mem_wait) begin
      for (int d = 0; d < ND; d++) begin
        if (!flush && id_valid && hz[d] && exp_sc[d] < scmax[d]) exp_sc[d]++;
        if (ex_mem_read && ex_reg_write && ex_rd != 0) ready[d][ex_rd] = tick + 1 + ll[d];
      end
      tick++;
    end
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    for (int d = 0; d < ND; d++) begin
      exp_sc[d] = 0;
      for (int r = 0; r < 32; r++) ready[d][r] = 0;
    end
    tick = 0;
    #1;
    check_outputs();
    reset = 1'b0;
    #1;
  endtask

  task automatic set_ex(input int kind, input logic [4:0] rd);
    ex_mem_read  = (kind == 1);
    ex_reg_write = (kind != 0);
    ex_rd        = rd;
  endtask

  task automatic stall_test(input string tag, input logic [31:0] instr, input logic valid,
                            input int kind, input int wait_at,
                            input int e0, input int e1, input int e2, input int e3);
    int n [ND];
    int ex [ND];
    logic [ND-1:0] done;
    ex = '{e0, e1, e2, e3};
    done = '0;
    for (int d = 0; d < ND; d++) n[d] = 0;
    flush = 0;
    mem_wait = 0;
    do_reset();
    id_instr = instr;
    id_valid = valid;
    set_ex(kind, 5'd5);
    for (int cyc = 0; cyc < 30 && !(&done); cyc++) begin
      mem_wait = (wait_at >= 0 && cyc >= wait_at && cyc < wait_at + 4);
      cycle();
      set_ex(0, 5'd0);
      for (int d = 0; d < ND; d++) begin
        if (!done[d]) begin
          if (last_pcw[d]) done[d] = 1'b1;
          else if (last_bub[d]) n[d]++;
        end
      end
    end
    mem_wait = 0;
    for (int d = 0; d < ND; d++) begin
      check({tag, "_released"}, d, 32'(done[d]), 32'd1);
      check({tag, "_stalls"}, d, 32'(n[d]), 32'(ex[d]));
      check({tag, "_stall_cnt"}, d, sc[d], 32'(ex[d]));
    end
  endtask

  initial begin
    logic [6:0] ops [8];
    ops = '{7'd51, 7'd19, 7'd3, 7'd35, 7'd99, 7'd103, 7'd55, 7'd111};
    @(posedge clk);
    #1;
    do_reset();

    stall_test("ld_add", mk(7'd51, 5'd6, 5'd5, 5'd7), 1'b1, 1, -1, 1, 3, 2, 2);
    stall_test("ld_addi_wait", mk(7'd19, 5'd8, 5'd5, 5'd4), 1'b1, 1, 1, 1, 3, 2, 2);
    stall_test("ld_beq", mk(7'd99, 5'd0, 5'd5, 5'd0), 1'b1, 1, -1, 2, 4, 3, 2);
    stall_test("alu_beq", mk(7'd99, 5'd0, 5'd5, 5'd1), 1'b1, 2, -1, 1, 1, 1, 0);
    stall_test("x0_src", mk(7'd51, 5'd6, 5'd0, 5'd0), 1'b1, 1, -1, 0, 0, 0, 0);
    stall_test("lui", mk(7'd55, 5'd5, 5'd5, 5'd5), 1'b1, 1, -1, 0, 0, 0, 0);
    stall_test("invalid", mk(7'd51, 5'd6, 5'd5, 5'd5), 1'b0, 1, -1, 0, 0, 0, 0);

    do_reset();
    id_valid = 0;
    set_ex(1, 5'd5);
    cycle();
    set_ex(0, 5'd0);
    id_instr = mk(7'd19, 5'd8, 5'd9, 5'd0);
    id_valid = 1;
    #1;
    check("indep_busy", 1, 32'(busy[1]), 32'd1);
    check("indep_pc_write", 1, 32'(pcw[1]), 32'd1);
    cycle();

    do_reset();
    id_instr = mk(7'd51, 5'd6, 5'd5, 5'd7);
    set_ex(1, 5'd5);
    flush = 1;
    cycle();
    flush = 0;
    set_ex(0, 5'd0);
    for (int d = 0; d < ND; d++) check("flush_stall_cnt", d, sc[d], 32'd0);
    cycle();

    do_reset();
    id_instr = mk(7'd51, 5'd6, 5'd5, 5'd7);
    set_ex(1, 5'd5);
    cycle();
    set_ex(0, 5'd0);
    #1;
    check("mid_stall_bubble", 2, 32'(bub[2]), 32'd1);
    do_reset();
    cycle();
    check("post_reset_pc_write", 2, 32'(last_pcw[2]), 32'd1);
    check("post_reset_busy", 2, 32'(busy[2]), 32'd0);

    for (int i = 0; i < 800; i++) begin
      id_instr        = $urandom;
      id_instr[6:0]   = ops[$urandom_range(0, 7)];
      id_instr[19:15] = 5'($urandom_range(0, 7));
      id_instr[24:20] = 5'($urandom_range(0, 7));
      id_valid        = ($urandom_range(0, 99) < 85);
      ex_mem_read     = ($urandom_range(0, 9) < 4);
      ex_reg_write    = ($urandom_range(0, 9) < 7);
      ex_rd           = 5'($urandom_range(0, 7));
      mem_wait        = ($urandom_range(0, 99) < 15);
      flush           = ($urandom_range(0, 99) < 10);
      if ($urandom_range(0, 99) == 0) do_reset();
      cycle();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
